tower_su3_sequencer: RTL and testbench

Initiator for the tower-layer SU(3) rotation core. It queues rotation commands (Gell-Mann axis and angle) and chains them through the core, feeding each output qutrit back as the next input. After the last command of a sequence it presents the composed qutrit on a valid/ready result port. It sits between the kingdom-layer control plane and `tower_su3_core`, which has no input handshake and only a free-running `valid_out`.

---
 rtl/tower_su3_pkg.sv | 28 ++
 rtl/tower_su3_sequencer_cmd_fifo.sv | 62 ++++++
 rtl/tower_su3_sequencer.sv | 175 +++++++++++++++++
 tb/tb_tower_su3_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tower_su3_pkg.sv
// Shared types and widths for the tower-layer SU(3) sequencer.
package tower_su3_pkg;

    localparam int AXIS_W   = 3;
    localparam int ANGLE_W  = 32;
    localparam int QUTRIT_W = 96;
    localparam int CMD_W    = 1 + AXIS_W + ANGLE_W;

    typedef struct packed {
        logic               last;
        logic [AXIS_W-1:0]  axis;
        logic [ANGLE_W-1:0] angle;
    } su3_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_FLUSH,
        ST_DONE
    } seq_state_t;

    // The rotation counter sticks at 255 rather than wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/tower_su3_sequencer_cmd_fifo.sv
// Command FIFO: DEPTH entries (power of two), registered occupancy count,
// pointers wrap naturally modulo DEPTH. rdata shows the head entry.
module tower_su3_sequencer_cmd_fifo
    import tower_su3_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [CMD_W-1:0] wdata,
    input  logic             pop,
    output logic [CMD_W-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Pointer and occupancy update; simultaneous push and pop leave count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
        if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/tower_su3_sequencer.sv
// Sequencer that chains queued SU(3) rotations through tower_su3_core and
// returns the composed qutrit on a valid/ready port.
// Optional build macro: TOWER_SU3_SEQ_SKIP_ZERO_EN (zero-angle commands
// bypass the core and cost one FETCH cycle).
//
// state | meaning
// IDLE  | waiting for seq_start; commands may still be queued
// FETCH | pop next command and launch it on the core (stall if empty)
// WAIT  | wait for core result, capture or time out
// FLUSH | discard queued commands up to and including the last one
// DONE  | result presented until res_ready
module tower_su3_sequencer
    import tower_su3_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int CORE_LAT = 1,
    parameter int TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_axis,
    input  logic [31:0]   cmd_angle,
    input  logic          cmd_last,
    input  logic          seq_start,
    input  logic [95:0]   seed_qutrit,
    output logic          seq_busy,
    output logic [2:0]    core_axis,
    output logic [31:0]   core_angle,
    output logic [95:0]   core_qutrit,
    input  logic          core_valid,
    input  logic [95:0]   core_result,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [95:0]   res_qutrit,
    output logic [7:0]    res_count,
    output logic          res_error
);

    localparam int WAIT_LIM = CORE_LAT + TIMEOUT;
    localparam int WAIT_W   = $clog2(WAIT_LIM + 1) + 1;

    seq_state_t          state_q, state_d;
    logic [QUTRIT_W-1:0] qutrit_q, qutrit_d;
    logic [7:0]          count_q, count_d;
    logic                error_q, error_d;
    logic                last_q, last_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [AXIS_W-1:0]   core_axis_q, core_axis_d;
    logic [ANGLE_W-1:0]  core_angle_q, core_angle_d;
    logic [QUTRIT_W-1:0] core_qutrit_q, core_qutrit_d;

    logic                fifo_pop, fifo_full, fifo_empty;
    logic [CMD_W-1:0]    fifo_rdata;
    su3_cmd_t            head;
    logic                skip_zero;

    tower_su3_sequencer_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .wdata ({cmd_last, cmd_axis, cmd_angle}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head = su3_cmd_t'(fifo_rdata);

`ifdef TOWER_SU3_SEQ_SKIP_ZERO_EN
    assign skip_zero = (head.angle == '0);
`else
    assign skip_zero = 1'b0;
`endif

    // Next-state and datapath decisions for the sequencing FSM.
    always_comb begin
        state_d       = state_q;
        qutrit_d      = qutrit_q;
        count_d       = count_q;
        error_d       = error_q;
        last_d        = last_q;
        wait_cnt_d    = wait_cnt_q;
        core_axis_d   = core_axis_q;
        core_angle_d  = core_angle_q;
        core_qutrit_d = core_qutrit_q;
        fifo_pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (seq_start) begin
                    qutrit_d = seed_qutrit;
                    count_d  = '0;
                    error_d  = 1'b0;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (skip_zero) begin
                        count_d = sat_inc8(count_q);
                        if (head.last) state_d = ST_DONE;
                    end else begin
                        core_axis_d   = head.axis;
                        core_angle_d  = head.angle;
                        core_qutrit_d = qutrit_q;
                        last_d        = head.last;
                        wait_cnt_d    = '0;
                        state_d       = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                if (wait_cnt_q >= WAIT_W'(CORE_LAT) && core_valid) begin
                    qutrit_d = core_result;
                    count_d  = sat_inc8(count_q);
                    state_d  = last_q ? ST_DONE : ST_FETCH;
                end else if (wait_cnt_q == WAIT_W'(WAIT_LIM - 1)) begin
                    // The increment happening now makes wait_cnt reach the limit.
                    error_d = 1'b1;
                    state_d = last_q ? ST_DONE : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head.last) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            qutrit_q      <= '0;
            count_q       <= '0;
            error_q       <= 1'b0;
            last_q        <= 1'b0;
            wait_cnt_q    <= '0;
            core_axis_q   <= '0;
            core_angle_q  <= '0;
            core_qutrit_q <= '0;
        end else begin
            state_q       <= state_d;
            qutrit_q      <= qutrit_d;
            count_q       <= count_d;
            error_q       <= error_d;
            last_q        <= last_d;
            wait_cnt_q    <= wait_cnt_d;
            core_axis_q   <= core_axis_d;
            core_angle_q  <= core_angle_d;
            core_qutrit_q <= core_qutrit_d;
        end
    end

    assign cmd_ready   = !fifo_full;
    assign seq_busy    = (state_q != ST_IDLE);
    assign res_valid   = (state_q == ST_DONE);
    assign res_qutrit  = qutrit_q;
    assign res_count   = count_q;
    assign res_error   = error_q;
    assign core_axis   = core_axis_q;
    assign core_angle  = core_angle_q;
    assign core_qutrit = core_qutrit_q;

endmodule

// File: tb/tb_tower_su3_sequencer.sv
// Scoreboard bench for tower_su3_sequencer with an XOR core model (latency 1).
module tb_tower_su3_sequencer;

    localparam logic [95:0] K = {32'hdeadbeef, 32'hcafebabe, 32'h0badf00d};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_axis = '0;
    logic [31:0] cmd_angle = '0;
    logic        cmd_last = 1'b0;
    logic        seq_start = 1'b0;
    logic [95:0] seed_qutrit = '0;
    logic        seq_busy;
    logic [2:0]  core_axis;
    logic [31:0] core_angle;
    logic [95:0] core_qutrit;
    logic        core_valid;
    logic [95:0] core_result;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [95:0] res_qutrit;
    logic [7:0]  res_count;
    logic        res_error;
    logic        core_en = 1'b0;

    typedef struct {
        logic [95:0] q;
        logic [7:0]  c;
        logic        e;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: one-cycle XOR, free-running valid.
    always @(posedge clk) core_result <= core_qutrit ^ K;
    assign core_valid = core_en;

    tower_su3_sequencer #(.DEPTH(8), .CORE_LAT(1), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_axis    (cmd_axis),
        .cmd_angle   (cmd_angle),
        .cmd_last    (cmd_last),
        .seq_start   (seq_start),
        .seed_qutrit (seed_qutrit),
        .seq_busy    (seq_busy),
        .core_axis   (core_axis),
        .core_angle  (core_angle),
        .core_qutrit (core_qutrit),
        .core_valid  (core_valid),
        .core_result (core_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_qutrit  (res_qutrit),
        .res_count   (res_count),
        .res_error   (res_error)
    );

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare each presented result against the scoreboard, verify it
    // is held for two extra cycles, then accept it.
    initial begin
        int          hold = 0;
        logic [95:0] hq;
        logic [7:0]  hc;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (res_ready) begin
                res_ready = 1'b0;
            end else if (res_valid) begin
                if (hold == 0) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: got res_valid=1 expected no pending result");
                    end else begin
                        e = sb.pop_front();
                        check("res_qutrit", res_qutrit, e.q);
                        check("res_count", 96'(res_count), 96'(e.c));
                        check("res_error", 96'(res_error), 96'(e.e));
                        if (e.cyc >= 0) check("res_valid_cycle", 96'(cyc), 96'(e.cyc));
                    end
                    hq = res_qutrit;
                    hc = res_count;
                end else begin
                    check("hold_qutrit", res_qutrit, hq);
                    check("hold_count", 96'(res_count), 96'(hc));
                end
                hold++;
                if (hold == 3) begin
                    res_ready = 1'b1;
                    hold = 0;
                end
            end
        end
    end

    task automatic push(input logic [2:0] ax, input logic [31:0] an, input logic l);
        cmd_valid = 1'b1;
        cmd_axis  = ax;
        cmd_angle = an;
        cmd_last  = l;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Issue seq_start; when use_sb, push the expected result (delay<0: no timing check).
    task automatic start(input logic [95:0] seed, input logic use_sb, input logic [95:0] eq,
                         input logic [7:0] ec, input logic ee, input int delay);
        exp_t e;
        seq_start   = 1'b1;
        seed_qutrit = seed;
        @(posedge clk);
        #1;
        if (use_sb) begin
            e.q = eq;
            e.c = ec;
            e.e = ee;
            e.cyc = (delay < 0) ? -1 : cyc + delay;
            sb.push_back(e);
        end
        @(negedge clk);
        seq_start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        while (seq_busy && k < max) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (seq_busy) begin
            n_fail++;
            $display("FAIL wait_idle: seq_busy=1 after %0d cycles expected 0", max);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 96'(cmd_ready), 96'(1));
        check("rst_seq_busy", 96'(seq_busy), 96'(0));
        check("rst_res_valid", 96'(res_valid), 96'(0));
        check("rst_res_error", 96'(res_error), 96'(0));
        check("rst_res_count", 96'(res_count), 96'(0));
        check("rst_res_qutrit", res_qutrit, 96'(0));
        check("rst_core_axis", 96'(core_axis), 96'(0));
        check("rst_core_angle", 96'(core_angle), 96'(0));
        check("rst_core_qutrit", core_qutrit, 96'(0));
        rst = 1'b0;
        @(negedge clk);

        // Single rotation from seed 0.
        core_en = 1'b1;
        push(3'd2, 32'd1, 1'b1);
        start(96'h0, 1'b1, K, 8'd1, 1'b0, 3);
        @(negedge clk);
        check("fetch_core_axis", 96'(core_axis), 96'(2));
        check("fetch_core_angle", 96'(core_angle), 96'(1));
        check("fetch_core_qutrit", core_qutrit, 96'(0));
        wait_idle(20);

        // Two rotations cancel.
        push(3'd1, 32'd7, 1'b0);
        push(3'd4, 32'd9, 1'b1);
        start(96'h1234, 1'b1, 96'h1234, 8'd2, 1'b0, 6);
        wait_idle(30);

        // Core never valid: timeout on the first command, flush the rest.
        core_en = 1'b0;
        push(3'd0, 32'd3, 1'b0);
        push(3'd5, 32'd4, 1'b0);
        push(3'd7, 32'd8, 1'b1);
        start(96'hABC, 1'b1, 96'hABC, 8'd0, 1'b1, 19);
        wait_idle(60);

        // Fill the FIFO: 8 accepted, the 9th refused.
        core_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cmd_valid = 1'b1;
            cmd_axis  = 3'(i);
            cmd_angle = 32'(i + 1);
            cmd_last  = (i >= 7);
            check("fill_cmd_ready", 96'(cmd_ready), 96'(i < 8));
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("full_cmd_ready", 96'(cmd_ready), 96'(0));
        start(96'h55, 1'b1, 96'h55, 8'd8, 1'b0, 24);
        check("prepop_cmd_ready", 96'(cmd_ready), 96'(0));
        @(negedge clk);
        check("postpop_cmd_ready", 96'(cmd_ready), 96'(1));
        wait_idle(60);

        // Reset during WAIT discards everything.
        for (int i = 0; i < 4; i++) push(3'(i), 32'(21 + i), (i == 3));
        start(96'h77, 1'b0, '0, 8'd0, 1'b0, -1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_seq_busy", 96'(seq_busy), 96'(0));
        check("rstmid_cmd_ready", 96'(cmd_ready), 96'(1));
        check("rstmid_res_valid", 96'(res_valid), 96'(0));
        @(negedge clk);
        rst = 1'b0;
        start(96'h99, 1'b1, 96'h99 ^ K, 8'd1, 1'b0, -1);
        repeat (5) @(negedge clk);
        check("stall_seq_busy", 96'(seq_busy), 96'(1));
        check("stall_core_angle", 96'(core_angle), 96'(0));
        push(3'd6, 32'd13, 1'b1);
        wait_idle(30);

        // Zero-angle command followed by a normal one.
        push(3'd3, 32'd0, 1'b0);
        push(3'd2, 32'd5, 1'b1);
`ifdef TOWER_SU3_SEQ_SKIP_ZERO_EN
        start(96'hF0, 1'b1, 96'hF0 ^ K, 8'd2, 1'b0, 4);
`else
        start(96'hF0, 1'b1, 96'hF0, 8'd2, 1'b0, 6);
`endif
        wait_idle(30);
        check("last_core_angle", 96'(core_angle), 96'(5));

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 96'(sb.size()), 96'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
